// File: rtl/tinyqv_prefetch_buffer.sv
// Instruction prefetch FIFO: DEPTH-byte ring between QSPI fetch and decoder, 32-bit window at pc.
// Latency: a captured byte appears in instr/avail_len the cycle after fetch_ready.
// Backpressure: fetch_stall warns the controller early; bytes arriving while full are dropped and flag overflow.
module tinyqv_prefetch_buffer #(
    parameter int DEPTH        = 8,
    parameter int PC_BITS      = 24,
    parameter int STALL_MARGIN = 2,
    localparam int CW          = $clog2(DEPTH) + 1,
    localparam int PW          = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [PC_BITS-2:0] flush_addr,
    input  logic [7:0]         fetch_data,
    input  logic               fetch_ready,
    input  logic               fetch_started,
    input  logic               fetch_stopped,
    output logic [PC_BITS-2:0] fetch_addr,
    output logic               fetch_restart,
    output logic               fetch_stall,
    output logic [31:0]        instr,
    output logic [CW-1:0]      avail_len,
    output logic [PC_BITS-2:0] pc,
    input  logic               consume,
    input  logic [2:0]         consume_len,
    output logic               overflow
);

    logic [7:0]         buf_q [DEPTH];
    logic [7:0]         buf_d [DEPTH];
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PC_BITS-2:0] pc_q, pc_d;
    logic               running_q, running_d;
    logic               overflow_q, overflow_d;

    logic               full;
    logic               capture;
    logic               consume_ok;
    logic [CW-1:0]      len_ext;
    logic [PW-1:0]      rd_idx;

    assign full       = (count_q == CW'(DEPTH));
    assign capture    = fetch_ready && running_q && !full;
    assign len_ext    = CW'(consume_len);
    assign consume_ok = consume && (consume_len == 3'd2 || consume_len == 3'd4)
                        && (len_ext <= count_q);

    always_comb begin
        buf_d      = buf_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pc_d       = pc_q;
        running_d  = running_q;
        overflow_d = overflow_q;

        if (flush) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            pc_d       = flush_addr;
            running_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (fetch_started) begin
                running_d = 1'b1;
            end else if (fetch_stopped) begin
                running_d = 1'b0;
            end

            // Full-check uses the pre-consume count, so a same-cycle consume never makes room.
            if (fetch_ready && running_q && full) begin
                overflow_d = 1'b1;
            end

            if (capture) begin
                buf_d[wr_ptr_q] = fetch_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end

            if (consume_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(consume_len);
                pc_d     = pc_q + (PC_BITS-1)'(consume_len[2:1]);
            end

            count_d = count_q + (capture ? CW'(1) : CW'(0)) - (consume_ok ? len_ext : CW'(0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pc_q       <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_q       <= pc_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    // Window bytes beyond the held count read as zero so the decoder never sees stale data.
    always_comb begin
        instr  = '0;
        rd_idx = '0;
        for (int i = 0; i < 4; i++) begin
            rd_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                instr[8*i +: 8] = buf_q[rd_idx];
            end
        end
    end

    assign avail_len     = count_q;
    assign pc            = pc_q;
    assign overflow      = overflow_q;
    assign fetch_stall   = ((CW'(DEPTH) - count_q) <= CW'(STALL_MARGIN));
    assign fetch_restart = !running_q && !flush;
    assign fetch_addr    = pc_q + (PC_BITS-1)'(count_q[CW-1:1]);

endmodule

// File: tb/tb_tinyqv_prefetch_buffer.sv
// Directed bench for tinyqv_prefetch_buffer (DEPTH=8, PC_BITS=24, STALL_MARGIN=2).
module tb_tinyqv_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [22:0] flush_addr;
    logic [7:0]  fetch_data;
    logic        fetch_ready;
    logic        fetch_started;
    logic        fetch_stopped;
    logic [22:0] fetch_addr;
    logic        fetch_restart;
    logic        fetch_stall;
    logic [31:0] instr;
    logic [3:0]  avail_len;
    logic [22:0] pc;
    logic        consume;
    logic [2:0]  consume_len;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tinyqv_prefetch_buffer #(.DEPTH(8), .PC_BITS(24), .STALL_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_addr(flush_addr),
        .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .fetch_started(fetch_started), .fetch_stopped(fetch_stopped),
        .fetch_addr(fetch_addr), .fetch_restart(fetch_restart), .fetch_stall(fetch_stall),
        .instr(instr), .avail_len(avail_len), .pc(pc),
        .consume(consume), .consume_len(consume_len), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fetch_data  = b;
        fetch_ready = 1'b1;
        step();
        fetch_ready = 1'b0;
    endtask

    task automatic cons(input logic [2:0] len);
        consume     = 1'b1;
        consume_len = len;
        step();
        consume     = 1'b0;
    endtask

    task automatic start();
        fetch_started = 1'b1;
        step();
        fetch_started = 1'b0;
    endtask

    task automatic do_flush(input logic [22:0] a);
        flush_addr = a;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_addr = '0; fetch_data = '0; fetch_ready = 1'b0;
        fetch_started = 1'b0; fetch_stopped = 1'b0; consume = 1'b0; consume_len = '0;
        step(); step();
        rst = 1'b0;
        step();

        // 1: reset in the middle of a stream clears everything immediately
        do_flush(23'h55);
        start();
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("mid_avail", 32'(avail_len), 32'd5);
        chk("mid_instr", instr, 32'h04030201);
        chk("mid_faddr", 32'(fetch_addr), 32'h57);
        rst = 1'b1;
        #1;
        chk("rst_avail", 32'(avail_len), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_restart", 32'(fetch_restart), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_stall", 32'(fetch_stall), 32'd0);
        chk("rst_faddr", 32'(fetch_addr), 32'h0);
        step();
        rst = 1'b0;
        step();

        // 2: basic 4-byte instruction
        flush_addr = 23'h100;
        flush = 1'b1;
        #1;
        chk("flush_restart_low", 32'(fetch_restart), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_pc", 32'(pc), 32'h100);
        chk("restart_high", 32'(fetch_restart), 32'd1);
        start();
        chk("running_restart", 32'(fetch_restart), 32'd0);
        push(8'h13); push(8'h00); push(8'h50); push(8'h00);
        chk("t2_avail", 32'(avail_len), 32'd4);
        chk("t2_instr", instr, 32'h00500013);
        chk("t2_pc", 32'(pc), 32'h100);
        chk("t2_faddr", 32'(fetch_addr), 32'h102);
        chk("t2_stall", 32'(fetch_stall), 32'd0);
        cons(3'd4);
        chk("t2_c_avail", 32'(avail_len), 32'd0);
        chk("t2_c_pc", 32'(pc), 32'h102);
        chk("t2_c_instr", instr, 32'h0);

        // 3: pointer wrap (rd_ptr/wr_ptr start at 4)
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        chk("w_instr0", instr, 32'hA3A2A1A0);
        cons(3'd2);
        chk("w_partial", instr, 32'h0000A3A2);
        chk("w_pc0", 32'(pc), 32'h103);
        push(8'hA4); push(8'hA5);
        chk("w_wrap", instr, 32'hA5A4A3A2);
        cons(3'd4);
        chk("w_avail0", 32'(avail_len), 32'd0);
        chk("w_pc1", 32'(pc), 32'h105);
        push(8'hA6); push(8'hA7); push(8'hA8); push(8'hA9);
        chk("w_instr2", instr, 32'hA9A8A7A6);
        cons(3'd2);
        chk("w_partial2", instr, 32'h0000A9A8);
        cons(3'd2);
        chk("w_pc2", 32'(pc), 32'h107);
        push(8'hB0);
        chk("odd_instr", instr, 32'h000000B0);
        chk("odd_faddr", 32'(fetch_addr), 32'h107);
        push(8'hB1);
        chk("even_faddr", 32'(fetch_addr), 32'h108);
        cons(3'd2);
        chk("w_pc3", 32'(pc), 32'h108);

        // 4: stall threshold and overflow (rd_ptr=wr_ptr=0 here)
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        chk("stall_c5", 32'(fetch_stall), 32'd0);
        push(8'hC5);
        chk("stall_c6", 32'(fetch_stall), 32'd1);
        cons(3'd2);
        chk("stall_c4", 32'(fetch_stall), 32'd0);
        for (int i = 6; i < 10; i++) push(8'(8'hC0 + i));
        chk("full_avail", 32'(avail_len), 32'd8);
        chk("full_ovf0", 32'(overflow), 32'd0);
        chk("full_stall", 32'(fetch_stall), 32'd1);
        push(8'hD0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_avail", 32'(avail_len), 32'd8);
        chk("ovf_instr", instr, 32'hC5C4C3C2);
        fetch_data = 8'hEE; fetch_ready = 1'b1; consume = 1'b1; consume_len = 3'd2;
        step();
        fetch_ready = 1'b0; consume = 1'b0;
        chk("full_cons_avail", 32'(avail_len), 32'd6);
        chk("full_cons_instr", instr, 32'hC7C6C5C4);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // 5: illegal consumes and simultaneous capture/consume
        do_flush(23'h200);
        chk("flush_ovf_clr", 32'(overflow), 32'd0);
        chk("flush_avail", 32'(avail_len), 32'd0);
        start();
        push(8'h11); push(8'h22); push(8'h33);
        cons(3'd4);
        chk("short_cons", 32'(avail_len), 32'd3);
        chk("short_pc", 32'(pc), 32'h200);
        cons(3'd3);
        chk("len3_ignored", 32'(avail_len), 32'd3);
        push(8'h44);
        fetch_data = 8'h55; fetch_ready = 1'b1; consume = 1'b1; consume_len = 3'd2;
        step();
        fetch_ready = 1'b0; consume = 1'b0;
        chk("sim_avail", 32'(avail_len), 32'd3);
        chk("sim_instr", instr, 32'h00554433);
        chk("sim_pc", 32'(pc), 32'h201);

        // 6: flush discards a same-cycle byte and stops capture until restarted
        fetch_data = 8'h66; fetch_ready = 1'b1; flush_addr = 23'h300; flush = 1'b1;
        #1;
        chk("f6_restart_low", 32'(fetch_restart), 32'd0);
        step();
        fetch_ready = 1'b0; flush = 1'b0;
        #1;
        chk("f6_avail", 32'(avail_len), 32'd0);
        chk("f6_instr", instr, 32'h0);
        chk("f6_pc", 32'(pc), 32'h300);
        chk("f6_restart_high", 32'(fetch_restart), 32'd1);
        push(8'h77);
        chk("f6_drop", 32'(avail_len), 32'd0);
        chk("f6_drop_ovf", 32'(overflow), 32'd0);
        start();
        push(8'h88);
        chk("f6_cap", 32'(avail_len), 32'd1);
        fetch_stopped = 1'b1;
        step();
        fetch_stopped = 1'b0;
        push(8'h99);
        chk("stopped_drop", 32'(avail_len), 32'd1);
        fetch_started = 1'b1; fetch_stopped = 1'b1;
        step();
        fetch_started = 1'b0; fetch_stopped = 1'b0;
        push(8'h9A);
        chk("start_wins", instr, 32'h00009A88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
